matvec_engine: RTL and testbench

Parametrised matrix-vector multiply engine; successor to the fixed 8-lane, 8-bit MAC array. It loads a COLS-element vector B, then streams COLS column beats of matrix A (ROWS elements per beat). It produces ROWS accumulated dot products with a selectable signed or unsigned mode and saturating, sticky-flagged accumulation. It sits between the memory-fetch/FIFO front end and the result display/readout logic at the top level.

---
 rtl/matvec_engine.sv | 113 +++++++++++
 tb/tb_matvec_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_engine.sv
// matvec_engine: streams a vector B and COLS column beats of A through ROWS saturating MAC lanes.
module matvec_engine #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_clr,
    input  logic                     i_b_valid,
    input  logic [DATA_W-1:0]        i_b_data,
    output logic                     o_b_ready,
    input  logic                     i_a_valid,
    input  logic [ROWS*DATA_W-1:0]   i_a_data,
    output logic                     o_a_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [ROWS*ACC_W-1:0]    o_acc_out,
    output logic [ROWS-1:0]          o_sat
);
    localparam int CW = $clog2(COLS + 1);
    localparam int PW = 2 * DATA_W;
    localparam logic [CW-1:0] LAST = CW'(COLS - 1);
    localparam logic [CW-1:0] FULL = CW'(COLS);
    localparam logic IS_S = SIGNED != 0;
    typedef enum logic [2:0] {IDLE, LOAD_B, COMPUTE, DRAIN, DONE} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_bidx, r_aidx;
    logic [DATA_W-1:0] r_b [2**CW];
    logic [PW-1:0] r_p [ROWS];
    logic r_pv;
    logic [ACC_W-1:0] r_acc [ROWS];
    logic [ROWS-1:0] r_sat;
    logic w_b_acc, w_a_acc;
    logic [DATA_W-1:0] w_bj;
    logic [PW-1:0] w_prod [ROWS];
    logic [ACC_W:0] w_sum [ROWS];
    logic [ACC_W-1:0] w_acc_nxt [ROWS];
    logic [ROWS-1:0] w_ovf;

    function automatic logic [PW-1:0] ext_op(input logic [DATA_W-1:0] v);
        return {{DATA_W{IS_S && v[DATA_W-1]}}, v};
    endfunction

    assign o_b_ready = r_state == LOAD_B;
    assign o_a_ready = r_state == COMPUTE && r_aidx != FULL;
    assign o_busy    = r_state != IDLE;
    assign o_done    = r_state == DONE && !i_clr;
    assign o_sat     = r_sat;
    assign w_b_acc   = i_b_valid && o_b_ready;
    assign w_a_acc   = i_a_valid && o_a_ready;
    assign w_bj      = r_b[r_aidx];

    for (genvar g = 0; g < ROWS; g++) begin : g_out
        assign o_acc_out[g*ACC_W +: ACC_W] = r_acc[g];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? LOAD_B : IDLE;
            LOAD_B:  w_next = (w_b_acc && r_bidx == LAST) ? COMPUTE : LOAD_B;
            COMPUTE: w_next = (r_aidx == FULL) ? DRAIN : COMPUTE;
            DRAIN:   w_next = DONE;
            default: w_next = IDLE;
        endcase
        if (i_clr)
            w_next = IDLE;
    end

    // The ACC_W+1 bit sum exposes overflow: carry-out when unsigned, top-two-bit disagreement when signed.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_prod[r]    = ext_op(i_a_data[r*DATA_W +: DATA_W]) * ext_op(w_bj);
            w_sum[r]     = {IS_S && r_acc[r][ACC_W-1], r_acc[r]}
                         + {{(ACC_W+1-PW){IS_S && r_p[r][PW-1]}}, r_p[r]};
            w_ovf[r]     = IS_S ? w_sum[r][ACC_W] ^ w_sum[r][ACC_W-1] : w_sum[r][ACC_W];
            w_acc_nxt[r] = !w_ovf[r] ? w_sum[r][ACC_W-1:0]
                         : !IS_S ? {ACC_W{1'b1}}
                         : w_sum[r][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                         : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr || (r_state == IDLE && i_start)) begin
            r_bidx <= '0;
            r_aidx <= '0;
            r_pv   <= 1'b0;
            r_sat  <= '0;
            for (int r = 0; r < ROWS; r++)
                r_acc[r] <= '0;
        end else begin
            if (w_b_acc) begin
                r_b[r_bidx] <= i_b_data;
                r_bidx      <= r_bidx + 1'b1;
            end
            if (w_a_acc) begin
                r_p    <= w_prod;
                r_aidx <= r_aidx + 1'b1;
            end
            r_pv <= w_a_acc;
            if (r_pv) begin
                r_acc <= w_acc_nxt;
                r_sat <= r_sat | w_ovf;
            end
        end
        r_state <= !i_rst_n ? IDLE : w_next;
    end
endmodule

// File: tb/tb_matvec_engine.sv
// tb_matvec_engine: four engine variants share one stimulus stream and are scored against an arithmetic model.
module tb_matvec_engine;
    localparam int R = 8;
    localparam int C = 8;
    logic clk = 0;
    logic rst_n = 0;
    logic start = 0;
    logic clr = 0;
    logic b_valid = 0;
    logic [7:0] b_data = 0;
    logic a_valid = 0;
    logic [R*8-1:0] a_data = 0;
    logic [3:0] b_rdy, a_rdy, busy, done;
    logic [7:0] sat_o [4];
    logic [R*24-1:0] acc0, acc2;
    logic [R*16-1:0] acc1, acc3;
    int aw [4] = '{24, 16, 24, 16};
    int sg [4] = '{0, 0, 1, 1};
    int A [R][C];
    int B [C];
    int nb [4], na [4], nd [4], done_cyc [4], sat_cyc [4];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matvec_engine #(.ACC_W(24), .SIGNED(0)) u0 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clr(clr),
        .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_rdy[0]), .i_a_valid(a_valid), .i_a_data(a_data),
        .o_a_ready(a_rdy[0]), .o_busy(busy[0]), .o_done(done[0]), .o_acc_out(acc0), .o_sat(sat_o[0]));
    matvec_engine #(.ACC_W(16), .SIGNED(0)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clr(clr),
        .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_rdy[1]), .i_a_valid(a_valid), .i_a_data(a_data),
        .o_a_ready(a_rdy[1]), .o_busy(busy[1]), .o_done(done[1]), .o_acc_out(acc1), .o_sat(sat_o[1]));
    matvec_engine #(.ACC_W(24), .SIGNED(1)) u2 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clr(clr),
        .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_rdy[2]), .i_a_valid(a_valid), .i_a_data(a_data),
        .o_a_ready(a_rdy[2]), .o_busy(busy[2]), .o_done(done[2]), .o_acc_out(acc2), .o_sat(sat_o[2]));
    matvec_engine #(.ACC_W(16), .SIGNED(1)) u3 (.i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clr(clr),
        .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_rdy[3]), .i_a_valid(a_valid), .i_a_data(a_data),
        .o_a_ready(a_rdy[3]), .o_busy(busy[3]), .o_done(done[3]), .o_acc_out(acc3), .o_sat(sat_o[3]));

    function automatic logic [63:0] dut_lane(input int k, input int r);
        case (k)
            0: return 64'(acc0[r*24 +: 24]);
            1: return 64'(acc1[r*16 +: 16]);
            2: return 64'(acc2[r*24 +: 24]);
            default: return 64'(acc3[r*16 +: 16]);
        endcase
    endfunction

    // Dot product with clamp after every beat; fj is the first beat that clamped.
    function automatic logic [63:0] model(input int k, input int r, output logic s, output int fj);
        longint acc, mx, mn, av, bv;
        mx = sg[k] != 0 ? (64'sd1 <<< (aw[k]-1)) - 1 : (64'sd1 <<< aw[k]) - 1;
        mn = sg[k] != 0 ? -(64'sd1 <<< (aw[k]-1)) : 0;
        acc = 0;
        s = 0;
        fj = -1;
        for (int j = 0; j < C; j++) begin
            av = A[r][j];
            bv = B[j];
            if (sg[k] != 0 && av > 127) av -= 256;
            if (sg[k] != 0 && bv > 127) bv -= 256;
            acc += av * bv;
            if (acc > mx || acc < mn) begin
                acc = acc > mx ? mx : mn;
                s = 1;
                if (fj < 0) fj = j;
            end
        end
        return 64'(acc & ((64'sd1 <<< aw[k]) - 1));
    endfunction

    // Drives one job; mode 0 no stalls, 1 valids on even cycles, 2 random valids.
    // clr_after >= 0 aborts once that many A beats have been accepted.
    task automatic run_job(input int mode, input int clr_after);
        int bi, ai;
        logic v;
        bi = 0;
        ai = 0;
        for (int k = 0; k < 4; k++) begin
            nb[k] = 0; na[k] = 0; nd[k] = 0; done_cyc[k] = -1; sat_cyc[k] = -1;
        end
        @(negedge clk);
        start = 1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            start = 0;
            for (int k = 0; k < 4; k++) begin
                if (b_rdy[k]) nb[k]++;
                if (a_rdy[k]) na[k]++;
                if (done[k]) begin
                    nd[k]++;
                    if (done_cyc[k] < 0) done_cyc[k] = c;
                end
                if (sat_o[k] != 0 && sat_cyc[k] < 0) sat_cyc[k] = c;
            end
            if (clr_after >= 0 && ai == clr_after) begin
                clr = 1; a_valid = 0; b_valid = 0;
                @(negedge clk);
                clr = 0;
                return;
            end
            v = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            b_valid = v && bi < C;
            b_data = bi < C ? 8'(B[bi]) : 8'h00;
            if (b_valid && b_rdy[0]) bi++;
            a_valid = v && ai < C;
            for (int r = 0; r < R; r++)
                a_data[r*8 +: 8] = ai < C ? 8'(A[r][ai]) : 8'h00;
            if (a_valid && a_rdy[0]) ai++;
        end
        b_valid = 0;
        a_valid = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({b_rdy[k], a_rdy[k], busy[k], done[k]} !== 4'b0) begin
                failures++;
                $display("FAIL reset_ctl dut%0d got %b required 0000", k, {b_rdy[k], a_rdy[k], busy[k], done[k]});
            end
            checks++;
            if (sat_o[k] !== 8'h00) begin
                failures++;
                $display("FAIL reset_sat dut%0d got %h required 00", k, sat_o[k]);
            end
            for (int r = 0; r < R; r++) begin
                checks++;
                if (dut_lane(k, r) !== 64'd0) begin
                    failures++;
                    $display("FAIL reset_acc dut%0d lane%0d got %h required 0", k, r, dut_lane(k, r));
                end
            end
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic load_ramp;
        for (int j = 0; j < C; j++) B[j] = j + 1;
        for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) A[r][j] = r + 1;
    endtask

    task automatic test_basic;
        logic s;
        int fj;
        logic [63:0] e;
        load_ramp();
        run_job(0, -1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (done_cyc[k] != 2*C+3 || nd[k] != 1) begin
                failures++;
                $display("FAIL basic_done dut%0d got cycle %0d count %0d required cycle %0d count 1", k, done_cyc[k], nd[k], 2*C+3);
            end
            checks++;
            if (nb[k] != C || na[k] != C || busy[k] !== 1'b0) begin
                failures++;
                $display("FAIL basic_ready dut%0d got b %0d a %0d busy %b required %0d %0d 0", k, nb[k], na[k], busy[k], C, C);
            end
            for (int r = 0; r < R; r++) begin
                e = model(k, r, s, fj);
                checks++;
                if (dut_lane(k, r) !== e || sat_o[k][r] !== s) begin
                    failures++;
                    $display("FAIL basic_acc dut%0d lane%0d got %h/%b required %h/%b", k, r, dut_lane(k, r), sat_o[k][r], e, s);
                end
            end
        end
        checks++;
        if (acc0[23:0] !== 24'h000024 || acc0[7*24 +: 24] !== 24'h000120) begin
            failures++;
            $display("FAIL basic_const got %h %h required 000024 000120", acc0[23:0], acc0[7*24 +: 24]);
        end
    endtask

    task automatic test_stall;
        logic s;
        int fj;
        logic [63:0] e;
        load_ramp();
        run_job(1, -1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (done_cyc[k] != 4*C+3 || nd[k] != 1 || nb[k] != 2*C || na[k] != 2*C) begin
                failures++;
                $display("FAIL stall_timing dut%0d got done %0d/%0d b %0d a %0d required %0d/1 %0d %0d",
                         k, done_cyc[k], nd[k], nb[k], na[k], 4*C+3, 2*C, 2*C);
            end
            for (int r = 0; r < R; r++) begin
                e = model(k, r, s, fj);
                checks++;
                if (dut_lane(k, r) !== e || sat_o[k][r] !== s) begin
                    failures++;
                    $display("FAIL stall_acc dut%0d lane%0d got %h/%b required %h/%b", k, r, dut_lane(k, r), sat_o[k][r], e, s);
                end
            end
        end
    endtask

    task automatic test_saturation;
        logic s;
        int fj;
        logic [63:0] e;
        for (int j = 0; j < C; j++) B[j] = 255;
        for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) A[r][j] = 255;
        run_job(0, -1);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < R; r++) begin
                e = model(k, r, s, fj);
                checks++;
                if (dut_lane(k, r) !== e || sat_o[k][r] !== s) begin
                    failures++;
                    $display("FAIL sat_acc dut%0d lane%0d got %h/%b required %h/%b", k, r, dut_lane(k, r), sat_o[k][r], e, s);
                end
            end
        e = model(1, 0, s, fj);
        checks++;
        if (sat_cyc[1] != C+3+fj) begin
            failures++;
            $display("FAIL sat_first got cycle %0d required %0d", sat_cyc[1], C+3+fj);
        end
        checks++;
        if (acc1 !== {R{16'hFFFF}} || sat_o[1] !== 8'hFF) begin
            failures++;
            $display("FAIL sat_const got %h/%h required all FFFF/FF", acc1, sat_o[1]);
        end
    endtask

    task automatic test_signed;
        logic s;
        int fj;
        logic [63:0] e;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < C; j++) B[j] = p == 0 ? j + 1 : 128;
            for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) A[r][j] = p == 0 ? 255 : 128;
            run_job(0, -1);
            for (int k = 0; k < 4; k++)
                for (int r = 0; r < R; r++) begin
                    e = model(k, r, s, fj);
                    checks++;
                    if (dut_lane(k, r) !== e || sat_o[k][r] !== s) begin
                        failures++;
                        $display("FAIL signed_acc p%0d dut%0d lane%0d got %h/%b required %h/%b", p, k, r, dut_lane(k, r), sat_o[k][r], e, s);
                    end
                end
            checks++;
            if (p == 0 ? (acc2 !== {R{24'hFFFFDC}} || sat_o[2] !== 8'h00) : (acc3 !== {R{16'h7FFF}} || sat_o[3] !== 8'hFF)) begin
                failures++;
                $display("FAIL signed_const p%0d got %h/%h %h/%h", p, acc2, sat_o[2], acc3, sat_o[3]);
            end
        end
    endtask

    task automatic test_clr;
        logic s;
        int fj;
        logic [63:0] e;
        load_ramp();
        run_job(0, 3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy[k] !== 1'b0 || sat_o[k] !== 8'h00 || nd[k] != 0) begin
                failures++;
                $display("FAIL clr_state dut%0d got busy %b sat %h done %0d required 0 00 0", k, busy[k], sat_o[k], nd[k]);
            end
            for (int r = 0; r < R; r++) begin
                checks++;
                if (dut_lane(k, r) !== 64'd0) begin
                    failures++;
                    $display("FAIL clr_acc dut%0d lane%0d got %h required 0", k, r, dut_lane(k, r));
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 4'b0 || busy !== 4'b0) begin
                failures++;
                $display("FAIL clr_idle got done %b busy %b required 0000 0000", done, busy);
            end
        end
        run_job(0, -1);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < R; r++) begin
                e = model(k, r, s, fj);
                checks++;
                if (dut_lane(k, r) !== e || sat_o[k][r] !== s) begin
                    failures++;
                    $display("FAIL clr_rerun dut%0d lane%0d got %h/%b required %h/%b", k, r, dut_lane(k, r), sat_o[k][r], e, s);
                end
            end
    endtask

    task automatic test_reset_mid;
        load_ramp();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        b_valid = 1;
        b_data = 8'h05;
        repeat (3) @(negedge clk);
        b_valid = 0;
        rst_n = 0;
        start = 1;
        clr = 1;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            rst_n = 1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if ({b_rdy[k], a_rdy[k], busy[k], done[k]} !== 4'b0 || sat_o[k] !== 8'h00) begin
                    failures++;
                    $display("FAIL rstmid_ctl p%0d dut%0d got %b sat %h required 0000 00", p, k, {b_rdy[k], a_rdy[k], busy[k], done[k]}, sat_o[k]);
                end
                for (int r = 0; r < R; r++) begin
                    checks++;
                    if (dut_lane(k, r) !== 64'd0) begin
                        failures++;
                        $display("FAIL rstmid_acc p%0d dut%0d lane%0d got %h required 0", p, k, r, dut_lane(k, r));
                    end
                end
            end
        end
        start = 0;
        clr = 0;
        @(negedge clk);
        checks++;
        if (busy !== 4'b0 || b_rdy !== 4'b0) begin
            failures++;
            $display("FAIL rstmid_idle got busy %b b_ready %b required 0000 0000", busy, b_rdy);
        end
    endtask

    task automatic test_random;
        logic s;
        int fj;
        logic [63:0] e;
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < C; j++) B[j] = $urandom_range(0, 255);
            for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) A[r][j] = $urandom_range(0, 255);
            run_job(t % 3, -1);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (nd[k] != 1 || busy[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_done t%0d dut%0d got %0d busy %b required 1 0", t, k, nd[k], busy[k]);
                end
                for (int r = 0; r < R; r++) begin
                    e = model(k, r, s, fj);
                    checks++;
                    if (dut_lane(k, r) !== e || sat_o[k][r] !== s) begin
                        failures++;
                        $display("FAIL rand_acc t%0d dut%0d lane%0d got %h/%b required %h/%b", t, k, r, dut_lane(k, r), sat_o[k][r], e, s);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_signed();
        test_clr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
